// File: rtl/mcu_bus_pkg.sv
// Shared types and defaults for the microcontroller data-memory bus.
package mcu_bus_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_IO  = 1'b1
  } owner_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_OWN = 2'd1,
    IO_OWN  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the arbiter and the data memory.
interface mem_bus_arbiter_if import mcu_bus_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;

  logic              io_req;
  logic              io_we;
  logic [ADDR_W-1:0] io_addr;
  logic [DATA_W-1:0] io_wdata;
  logic              io_gnt;
  logic              io_rvalid;

  logic [DATA_W-1:0] rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  io_req, io_we, io_addr, io_wdata,
    input  mem_rdata,
    output cpu_gnt, cpu_rvalid, io_gnt, io_rvalid, rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requester/memory side.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output io_req, io_we, io_addr, io_wdata,
    output mem_rdata,
    input  cpu_gnt, cpu_rvalid, io_gnt, io_rvalid, rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin selector: a tie goes to whoever did not own last.
module rr_pick2 import mcu_bus_pkg::*; (
  input  logic   req0,
  input  logic   req1,
  input  owner_t last_owner,
  output owner_t winner
);

  always_comb begin
    winner = last_owner;
    if (req0 && !req1) begin
      winner = OWN_CPU;
    end else if (req1 && !req0) begin
      winner = OWN_IO;
    end else if (req0 && req1) begin
      winner = (last_owner == OWN_CPU) ? OWN_IO : OWN_CPU;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// CPU/DMA arbiter for the single-port data memory: round-robin ownership with
// bounded bursts, combinational beat issue, and 1-cycle read return tracking.
module mem_bus_arbiter import mcu_bus_pkg::*; #(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  mem_bus_arbiter_if.slave bus
);

  localparam int CNT_W = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST);

  arb_state_t        state;
  owner_t            last_owner;
  owner_t            winner;
  logic [CNT_W-1:0]  beat_cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              rd_pend_cpu;
  logic              rd_pend_io;

  logic              own_cpu, own_io;
  logic              beat_cpu, beat_io, beat;
  logic              burst_done;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_pick2 u_pick (
    .req0       (bus.cpu_req),
    .req1       (bus.io_req),
    .last_owner (last_owner),
    .winner     (winner)
  );

  assign own_cpu    = (state == CPU_OWN);
  assign own_io     = (state == IO_OWN);
  assign beat_cpu   = own_cpu & bus.cpu_req;
  assign beat_io    = own_io & bus.io_req;
  assign beat       = beat_cpu | beat_io;
  assign cnt_next   = beat_cnt + CNT_W'(1);
  assign burst_done = (cnt_next == BURST_LAST);

  // Idle bus drives zeros so the memory pins are quiet outside beats.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (beat_cpu) begin
      sel_we    = bus.cpu_we;
      sel_addr  = bus.cpu_addr;
      sel_wdata = bus.cpu_wdata;
    end else if (beat_io) begin
      sel_we    = bus.io_we;
      sel_addr  = bus.io_addr;
      sel_wdata = bus.io_wdata;
    end
  end

  assign bus.mem_en     = beat;
  assign bus.mem_we     = sel_we;
  assign bus.mem_addr   = sel_addr;
  assign bus.mem_wdata  = sel_wdata;

  assign bus.cpu_gnt    = own_cpu;
  assign bus.io_gnt     = own_io;
  assign bus.cpu_rvalid = rd_pend_cpu;
  assign bus.io_rvalid  = rd_pend_io;
  assign bus.rdata      = (rd_pend_cpu | rd_pend_io) ? bus.mem_rdata : '0;

  // A drop of req always wins over burst expiry: no beat, hand over or go idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_owner  <= OWN_IO;
      beat_cnt    <= '0;
      rd_pend_cpu <= 1'b0;
      rd_pend_io  <= 1'b0;
    end else begin
      rd_pend_cpu <= beat_cpu & ~bus.cpu_we;
      rd_pend_io  <= beat_io & ~bus.io_we;
      unique case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (bus.cpu_req || bus.io_req) begin
            state <= (winner == OWN_CPU) ? CPU_OWN : IO_OWN;
          end
        end
        CPU_OWN: begin
          if (!bus.cpu_req) begin
            beat_cnt <= '0;
            state    <= bus.io_req ? IO_OWN : IDLE;
          end else begin
            last_owner <= OWN_CPU;
            if (burst_done) begin
              beat_cnt <= '0;
              if (bus.io_req) state <= IO_OWN;
            end else begin
              beat_cnt <= cnt_next;
            end
          end
        end
        IO_OWN: begin
          if (!bus.io_req) begin
            beat_cnt <= '0;
            state    <= bus.cpu_req ? CPU_OWN : IDLE;
          end else begin
            last_owner <= OWN_IO;
            if (burst_done) begin
              beat_cnt <= '0;
              if (bus.cpu_req) state <= CPU_OWN;
            end else begin
              beat_cnt <= cnt_next;
            end
          end
        end
        default: begin
          state    <= IDLE;
          beat_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a 1-cycle-latency memory model.
module tb_mem_bus_arbiter;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 16;
  localparam int MAX_BURST = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  // Memory model: unwritten words read back a fixed per-address pattern.
  logic [DATA_W-1:0] mem [256];
  logic [255:0]      written = '0;

  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    case (a)
      8'h10:   return 16'hBEEF;
      8'h20:   return 16'h1234;
      8'h21:   return 16'h5678;
      default: return {8'hC0, a};
    endcase
  endfunction

  always @(posedge clk) begin
    if (bif.mem_en) begin
      if (bif.mem_we) begin
        mem[bif.mem_addr]     <= bif.mem_wdata;
        written[bif.mem_addr] <= 1'b1;
      end else begin
        bif.mem_rdata <= written[bif.mem_addr] ? mem[bif.mem_addr] : init_val(bif.mem_addr);
      end
    end
  end

  task automatic idle_inputs();
    bif.cpu_req = 1'b0; bif.cpu_we = 1'b0; bif.cpu_addr = '0; bif.cpu_wdata = '0;
    bif.io_req  = 1'b0; bif.io_we  = 1'b0; bif.io_addr  = '0; bif.io_wdata  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk); #1;
    checks++;
    if (bif.cpu_gnt !== 1'b0 || bif.io_gnt !== 1'b0)
      begin errors++; $display("FAIL reset_gnt: got cpu=%b io=%b expected 0 0", bif.cpu_gnt, bif.io_gnt); end
    checks++;
    if (bif.cpu_rvalid !== 1'b0 || bif.io_rvalid !== 1'b0 || bif.rdata !== 16'h0000)
      begin errors++; $display("FAIL reset_rvalid: got %b %b %h expected 0 0 0000", bif.cpu_rvalid, bif.io_rvalid, bif.rdata); end
    checks++;
    if (bif.mem_en !== 1'b0 || bif.mem_we !== 1'b0 || bif.mem_addr !== 8'h00 || bif.mem_wdata !== 16'h0000)
      begin errors++; $display("FAIL reset_mem: got en=%b we=%b a=%h d=%h expected 0 0 00 0000", bif.mem_en, bif.mem_we, bif.mem_addr, bif.mem_wdata); end
  endtask

  task automatic test_reset_priority();
    logic exp_c, exp_i;
    do_reset();
    bif.cpu_req = 1'b1; bif.cpu_we = 1'b1; bif.cpu_addr = 8'h40; bif.cpu_wdata = 16'h1111;
    bif.io_req  = 1'b1; bif.io_we  = 1'b1; bif.io_addr  = 8'h50; bif.io_wdata  = 16'h2222;
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      exp_c = (k >= 1 && k <= 4) || (k == 9);
      exp_i = (k >= 5 && k <= 8);
      checks++;
      if (bif.cpu_gnt !== exp_c || bif.io_gnt !== exp_i)
        begin errors++; $display("FAIL prio_gnt k=%0d: got cpu=%b io=%b expected %b %b", k, bif.cpu_gnt, bif.io_gnt, exp_c, exp_i); end
      checks++;
      if (bif.mem_en !== (exp_c | exp_i))
        begin errors++; $display("FAIL prio_mem_en k=%0d: got %b expected %b", k, bif.mem_en, exp_c | exp_i); end
    end
    idle_inputs();
  endtask

  task automatic test_read_latency();
    do_reset();
    bif.cpu_req = 1'b1; bif.cpu_we = 1'b0; bif.cpu_addr = 8'h10;
    #1;
    checks++;
    if (bif.cpu_gnt !== 1'b0 || bif.mem_en !== 1'b0)
      begin errors++; $display("FAIL rd_idle: got gnt=%b en=%b expected 0 0", bif.cpu_gnt, bif.mem_en); end
    @(negedge clk); #1;
    checks++;
    if (bif.mem_en !== 1'b1 || bif.mem_we !== 1'b0 || bif.mem_addr !== 8'h10 || bif.cpu_rvalid !== 1'b0)
      begin errors++; $display("FAIL rd_issue: got en=%b we=%b a=%h rv=%b expected 1 0 10 0", bif.mem_en, bif.mem_we, bif.mem_addr, bif.cpu_rvalid); end
    @(negedge clk);
    bif.cpu_req = 1'b0;
    #1;
    checks++;
    if (bif.cpu_rvalid !== 1'b1 || bif.rdata !== 16'hBEEF || bif.io_rvalid !== 1'b0)
      begin errors++; $display("FAIL rd_return: got rv=%b rdata=%h io_rv=%b expected 1 beef 0", bif.cpu_rvalid, bif.rdata, bif.io_rvalid); end
    @(negedge clk); #1;
    checks++;
    if (bif.cpu_rvalid !== 1'b0 || bif.rdata !== 16'h0000 || bif.cpu_gnt !== 1'b0)
      begin errors++; $display("FAIL rd_after: got rv=%b rdata=%h gnt=%b expected 0 0000 0", bif.cpu_rvalid, bif.rdata, bif.cpu_gnt); end
  endtask

  task automatic test_burst_fairness();
    int nc = 0, ni = 0;
    logic exp_c, exp_i;
    do_reset();
    bif.cpu_req = 1'b1; bif.cpu_we = 1'b1; bif.cpu_addr = 8'h70; bif.cpu_wdata = 16'hAAAA;
    bif.io_req  = 1'b1; bif.io_we  = 1'b1; bif.io_addr  = 8'h71; bif.io_wdata  = 16'h5555;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      exp_c = (k >= 1) && ((((k - 1) / 4) % 2) == 0);
      exp_i = (k >= 1) && ((((k - 1) / 4) % 2) == 1);
      checks++;
      if (bif.cpu_gnt !== exp_c || bif.io_gnt !== exp_i || bif.mem_en !== (exp_c | exp_i))
        begin errors++; $display("FAIL fair k=%0d: got cpu=%b io=%b en=%b expected %b %b %b", k, bif.cpu_gnt, bif.io_gnt, bif.mem_en, exp_c, exp_i, exp_c | exp_i); end
      if (bif.mem_en === 1'b1 && bif.cpu_gnt === 1'b1) nc++;
      if (bif.mem_en === 1'b1 && bif.io_gnt === 1'b1) ni++;
    end
    checks++;
    if (nc != 20 || ni != 19)
      begin errors++; $display("FAIL fair_counts: got cpu=%0d io=%0d expected 20 19", nc, ni); end
    idle_inputs();
  endtask

  task automatic test_sole_requester();
    int nb = 0;
    do_reset();
    bif.io_req = 1'b1; bif.io_we = 1'b1; bif.io_addr = 8'h03; bif.io_wdata = 16'h00A5;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++;
      if (bif.io_gnt !== (k >= 1) || bif.cpu_gnt !== 1'b0)
        begin errors++; $display("FAIL sole_gnt k=%0d: got io=%b cpu=%b expected %b 0", k, bif.io_gnt, bif.cpu_gnt, k >= 1); end
      if (k >= 1) begin
        checks++;
        if (bif.mem_en !== 1'b1 || bif.mem_we !== 1'b1 || bif.mem_addr !== 8'h03 || bif.mem_wdata !== 16'h00A5)
          begin errors++; $display("FAIL sole_beat k=%0d: got en=%b we=%b a=%h d=%h expected 1 1 03 00a5", k, bif.mem_en, bif.mem_we, bif.mem_addr, bif.mem_wdata); end
      end
      if (bif.mem_en === 1'b1) nb++;
    end
    checks++;
    if (nb != 10)
      begin errors++; $display("FAIL sole_beats: got %0d expected 10", nb); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (bif.io_gnt !== 1'b1 || bif.mem_en !== 1'b0 || written[3] !== 1'b1 || mem[3] !== 16'h00A5)
      begin errors++; $display("FAIL sole_drop: got gnt=%b en=%b mem3=%h expected 1 0 00a5", bif.io_gnt, bif.mem_en, mem[3]); end
  endtask

  task automatic test_release_switch();
    do_reset();
    bif.cpu_req = 1'b1; bif.cpu_we = 1'b0; bif.cpu_addr = 8'h20;
    bif.io_req  = 1'b1; bif.io_we  = 1'b1; bif.io_addr  = 8'h60; bif.io_wdata = 16'h3333;
    @(negedge clk); #1;
    checks++;
    if (bif.cpu_gnt !== 1'b1 || bif.mem_en !== 1'b1 || bif.mem_addr !== 8'h20)
      begin errors++; $display("FAIL sw_beat1: got gnt=%b en=%b a=%h expected 1 1 20", bif.cpu_gnt, bif.mem_en, bif.mem_addr); end
    @(negedge clk);
    bif.cpu_addr = 8'h21;
    #1;
    checks++;
    if (bif.mem_addr !== 8'h21 || bif.cpu_rvalid !== 1'b1 || bif.rdata !== 16'h1234)
      begin errors++; $display("FAIL sw_beat2: got a=%h rv=%b rdata=%h expected 21 1 1234", bif.mem_addr, bif.cpu_rvalid, bif.rdata); end
    @(negedge clk);
    bif.cpu_req = 1'b0;
    #1;
    checks++;
    if (bif.cpu_gnt !== 1'b1 || bif.io_gnt !== 1'b0 || bif.mem_en !== 1'b0 || bif.cpu_rvalid !== 1'b1 || bif.rdata !== 16'h5678)
      begin errors++; $display("FAIL sw_drop: got cg=%b ig=%b en=%b rv=%b rdata=%h expected 1 0 0 1 5678", bif.cpu_gnt, bif.io_gnt, bif.mem_en, bif.cpu_rvalid, bif.rdata); end
    @(negedge clk); #1;
    checks++;
    if (bif.io_gnt !== 1'b1 || bif.cpu_gnt !== 1'b0 || bif.mem_en !== 1'b1 || bif.mem_we !== 1'b1 || bif.mem_addr !== 8'h60 || bif.cpu_rvalid !== 1'b0)
      begin errors++; $display("FAIL sw_io: got ig=%b cg=%b en=%b we=%b a=%h rv=%b expected 1 0 1 1 60 0", bif.io_gnt, bif.cpu_gnt, bif.mem_en, bif.mem_we, bif.mem_addr, bif.cpu_rvalid); end
    idle_inputs();
  endtask

  task automatic test_mid_reset();
    do_reset();
    bif.io_req = 1'b1; bif.io_we = 1'b0; bif.io_addr = 8'h30;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bif.io_gnt !== 1'b1 || bif.io_rvalid !== 1'b1 || bif.rdata !== 16'hC030)
      begin errors++; $display("FAIL mr_burst: got gnt=%b rv=%b rdata=%h expected 1 1 c030", bif.io_gnt, bif.io_rvalid, bif.rdata); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bif.io_gnt !== 1'b0 || bif.cpu_gnt !== 1'b0 || bif.io_rvalid !== 1'b0 || bif.mem_en !== 1'b0 || bif.rdata !== 16'h0000)
      begin errors++; $display("FAIL mr_async: got ig=%b cg=%b rv=%b en=%b rdata=%h expected 0 0 0 0 0000", bif.io_gnt, bif.cpu_gnt, bif.io_rvalid, bif.mem_en, bif.rdata); end
    @(negedge clk);
    rst = 1'b0;
    bif.cpu_req = 1'b1; bif.cpu_we = 1'b1; bif.cpu_addr = 8'h31; bif.cpu_wdata = 16'h4444;
    #1;
    checks++;
    if (bif.cpu_gnt !== 1'b0 || bif.io_gnt !== 1'b0)
      begin errors++; $display("FAIL mr_idle: got cpu=%b io=%b expected 0 0", bif.cpu_gnt, bif.io_gnt); end
    @(negedge clk); #1;
    checks++;
    if (bif.cpu_gnt !== 1'b1 || bif.io_gnt !== 1'b0)
      begin errors++; $display("FAIL mr_tie: got cpu=%b io=%b expected 1 0", bif.cpu_gnt, bif.io_gnt); end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_reset_priority();
    test_read_latency();
    test_burst_fairness();
    test_sole_requester();
    test_release_switch();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Two-requester arbiter for the shared single-port data memory of the 16-bit microcontroller. Requester 0 is the CPU load/store unit; requester 1 is the port DMA engine that moves P1 input samples to memory and memory data to the P0 output buffer. Ownership is round-robin with bounded bursts, so neither side can starve the other. The memory is synchronous with 1-cycle read latency.

Parameters:
ADDR_W, 8, memory word-address width
DATA_W, 16, data word width
MAX_BURST, 4, maximum consecutive beats for one owner while the other requester waits (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
cpu_req  in  1  CPU requests a beat; held with cpu_we/cpu_addr/cpu_wdata valid
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  beat address
cpu_wdata  in  DATA_W  write data
cpu_gnt  out  1  CPU owns bus; beat accepted when cpu_req & cpu_gnt
cpu_rvalid  out  1  read data valid for CPU
io_req / io_we / io_addr / io_wdata  in  1/1/ADDR_W/DATA_W  same as CPU set, DMA side
io_gnt  out  1  DMA owns bus
io_rvalid  out  1  read data valid for DMA
rdata  out  DATA_W  read data, shared by both requesters, qualified by *_rvalid
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid 1 cycle after read strobe

Behaviour:
- States: IDLE, CPU_OWN, IO_OWN. Registers: state, last_owner, beat_cnt (covers 0..MAX_BURST), rd_pend_cpu, rd_pend_io.
- Reset (async, any time): state=IDLE, last_owner=IO, beat_cnt=0, rd_pend_*=0. Outputs: gnt=0, rvalid=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0. In-flight read results are discarded.
- cpu_gnt = (state==CPU_OWN); io_gnt = (state==IO_OWN). Both are decoded from registered state, never asserted together.
- IDLE: exactly one req -> that owner next cycle. Both reqs -> the owner != last_owner, so CPU wins the first tie after reset. No req -> stay. No beat is issued in IDLE (1-cycle grant latency from IDLE).
- X_OWN, req_X=1: a beat is issued combinationally: mem_en=1; mem_we/mem_addr/mem_wdata = X's inputs. beat_cnt++ and last_owner=X.
- X_OWN exit, evaluated each cycle:
  - req_X=0: go to Y_OWN if req_Y=1, else IDLE; beat_cnt=0; no beat that cycle.
  - Beat issued with beat_cnt reaching MAX_BURST and req_Y=1: next state Y_OWN, beat_cnt=0. The handover has no idle gap; Y's first beat is issued the next cycle.
  - Beat issued with beat_cnt reaching MAX_BURST and req_Y=0: stay in X_OWN, beat_cnt=0.
- req_X dropping in the same cycle that MAX_BURST would be reached: the drop rule applies (no beat issued).
- Read return: a read beat for X sets rd_pend_X for exactly the next cycle. X_rvalid = rd_pend_X and rdata = mem_rdata (registered through) in that cycle. After an owner switch, the previous owner's last read still returns its rvalid one cycle after issue. Back-to-back reads give back-to-back rvalid.
- Writes complete in the issue cycle and produce no response.
- Requesters must keep req and the beat fields stable until accepted (req & gnt); changing them while req=1 and gnt=0 is illegal.

Decomposition:
- Shared package mcu_bus_pkg holds: the owner encoding (OWN_CPU=0, OWN_IO=1), the arbiter state encoding (IDLE/CPU_OWN/IO_OWN), and the DATA_W/ADDR_W defaults reused by the toplevel.
- One natural sub-module: rr_pick2, the combinational 2-way round-robin selector (inputs: two reqs and last_owner; output: winner).
- Counter, FSM and muxes stay in mem_bus_arbiter.

Test Plan:
- Reset priority: rst 1->0, then cpu_req=io_req=1 -> cpu_gnt=1 on cycle 2; io waits MAX_BURST=4 CPU beats; io_gnt rises the cycle after the 4th beat, with no idle gap.
- Read latency: CPU reads addr 0x10 (memory model holds 0xBEEF) -> cpu_rvalid=1, rdata=0xBEEF exactly 1 cycle after the beat; io_rvalid stays 0.
- Burst fairness: both request continuously for 40 cycles -> grants alternate in 4-beat groups; beat counts CPU=IO=±4; mem_en never overlaps ownership errors.
- Sole requester: io_req held alone for 10 cycles -> io_gnt continuous, 10 beats, counter wraps with no yield; a write of 0x00A5 to addr 0x03 appears on mem_* in its grant cycle.
- Release/switch: CPU drops req after 2 beats while io_req=1 -> io_gnt asserts the next cycle. The CPU's last read's rvalid still arrives after the switch, with the correct rdata.
- Mid-operation reset: assert rst during an IO read burst -> all gnt/rvalid/mem_en drop immediately (asynchronously); after release, the first tie goes to CPU.
